// File: rtl/speech_sample_fetcher.sv
// speech_sample_fetcher: Avalon-MM flash read master that plays each 32-bit word as two signed 16-bit samples paced by sample_tick.
// Optional feature macro: REVERSE_PLAY_EN (descending addresses, high half played first).
module speech_sample_fetcher #(
  parameter int ADDR_W = 23,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  word_count,
`ifdef REVERSE_PLAY_EN
  input  logic              reverse,
`endif
  input  logic              sample_tick,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_address,
  input  logic              flash_waitrequest,
  input  logic [31:0]       flash_readdata,
  input  logic              flash_readdatavalid,
  output logic [15:0]       sample_out,
  output logic              sample_valid,
  output logic              busy,
  output logic              done,
  output logic              underrun
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT_DATA, PLAY_LO, PLAY_HI, NEXT, DONE} state_e;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0] word_q;
  logic [15:0] sample_q;
  logic pend_q, rev_q, busy_q, done_q, valid_q, underrun_q;
  logic accept, active, consume, rev_d;
`ifdef REVERSE_PLAY_EN
  assign rev_d = reverse;
`else
  assign rev_d = 1'b0;
`endif
  assign flash_address = addr_q;
  assign sample_out    = sample_q;
  assign sample_valid  = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign underrun      = underrun_q;
  // state register; reset aborts any fetch immediately
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  // next-state: one read per word, two ticks per word, then advance or finish
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = (word_count == '0) ? DONE : REQ;
      REQ:       if (!flash_waitrequest) state_d = WAIT_DATA;
      WAIT_DATA: if (flash_readdatavalid) state_d = PLAY_LO;
      PLAY_LO:   if (consume) state_d = PLAY_HI;
      PLAY_HI:   if (consume) state_d = NEXT;
      NEXT:      state_d = (cnt_q == CNT_W'(1)) ? DONE : REQ;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  // outputs decoded from state: read strobe drops as soon as state leaves REQ (including async reset)
  always_comb begin
    flash_read = state_q == REQ;
    accept     = state_q == IDLE && start;
    active     = state_q != IDLE && state_q != DONE;
    consume    = (state_q == PLAY_LO || state_q == PLAY_HI) && (sample_tick || pend_q);
  end
  // datapath: fetch bookkeeping, word capture, sample release and tick-pending/underrun tracking
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      sample_q   <= '0;
      pend_q     <= 1'b0;
      rev_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      valid_q <= consume;
      done_q  <= state_q == DONE;
      if (accept) begin
        addr_q <= start_addr;
        cnt_q  <= word_count;
        rev_q  <= rev_d;
        busy_q <= 1'b1;
      end
      if (state_q == DONE) busy_q <= 1'b0;
      if (state_q == WAIT_DATA && flash_readdatavalid) word_q <= flash_readdata;
      if (consume) sample_q <= ((state_q == PLAY_LO) ^ rev_q) ? word_q[15:0] : word_q[31:16];
      if (state_q == NEXT) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q != CNT_W'(1)) addr_q <= rev_q ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
      end
      pend_q     <= !active ? 1'b0 : consume ? pend_q & sample_tick : pend_q | sample_tick;
      underrun_q <= accept ? 1'b0 : underrun_q | (active & pend_q & sample_tick & !consume);
    end
  end
endmodule
